// File: rtl/fetch_stage_pkg.sv
// Shared core package: word width, reset PC and bubble encoding defaults,
// fetch FSM state encoding, and a PC increment helper. Also imported by
// decode and hazard control, so the bubble encoding stays consistent.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 16;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_PC_DEFAULT  = 16'h0000;
    localparam word_t NOP_INSTR_DEFAULT = 16'h0000;

    // FETCH: request outstanding on the instruction bus.
    // HOLD : skid buffer full, request suppressed until IF/ID frees up.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    // 16-bit wrapping word-address increment (16'hFFFF -> 16'h0000).
    function automatic word_t pc_next(input word_t pc);
        return pc + word_t'(1);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req   : request valid (fetch -> memory)
//   imem_addr  : word address of the request (fetch -> memory)
//   imem_ready : memory accepts the request this cycle (memory -> fetch)
//   imem_rdata : instruction word, valid when imem_req && imem_ready
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ready;
    word_t imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched {instr, pc} pair while IF/ID is
// stalled.
//   clk, rst   : clock, synchronous active-high reset (empties the buffer)
//   load       : capture load_instr/load_pc and mark full
//   drain      : entry consumed, mark empty
//   flush      : discard the entry (redirect); wins over load and drain
//   instr, pc  : held entry
//   full       : entry valid
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  drain,
    input  logic  flush,
    input  word_t load_instr,
    input  word_t load_pc,
    output word_t instr,
    output word_t pc,
    output logic  full
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while full is set.
    always_ff @(posedge clk) begin
        if (load) begin
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one request at a time on the
// instruction bus, and fills the IF/ID pipeline register. A one-entry skid
// buffer catches a word that completes while IF/ID is stalled.
//   clk, rst        : clock, synchronous active-high reset
//   if_id_stall     : hold IF/ID contents (hazard control)
//   redirect_valid  : taken branch/jump; highest priority after reset
//   redirect_pc     : redirect target word address
//   bus             : instruction memory bus (master side)
//   id_instr        : IF/ID instruction (NOP_INSTR when bubble)
//   id_pc           : PC of id_instr
//   id_valid        : id_instr is a real instruction
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEFAULT,
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_id_stall,
    input  logic                 redirect_valid,
    input  word_t                redirect_pc,
    fetch_stage_if.master        bus,
    output word_t                id_instr,
    output word_t                id_pc,
    output logic                 id_valid
);

    fetch_state_e state_q, state_d;
    word_t        pc_q;
    logic         fire;
    logic         skid_load, skid_drain, skid_full;
    word_t        skid_instr, skid_pc;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH: if (fire && if_id_stall) state_d = HOLD;
                HOLD:  if (!if_id_stall)        state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Request is a function of state only; rst merely masks it so nothing
    // is issued while the core is being reset.
    always_comb begin
        bus.imem_req  = (state_q == FETCH) && !rst;
        bus.imem_addr = pc_q;
    end

    assign fire = bus.imem_req && bus.imem_ready;

    // ---------------- skid buffer ----------------
    assign skid_load  = fire && if_id_stall && !redirect_valid;
    assign skid_drain = skid_full && !if_id_stall && !redirect_valid;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .drain      (skid_drain),
        .flush      (redirect_valid),
        .load_instr (bus.imem_rdata),
        .load_pc    (pc_q),
        .instr      (skid_instr),
        .pc         (skid_pc),
        .full       (skid_full)
    );

    // ---------------- PC ----------------
    // PC only moves on completion or redirect, so imem_addr is stable
    // for the whole life of a request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
        end else if (fire) begin
            pc_q <= pc_next(pc_q);
        end
    end

    // ---------------- IF/ID register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            id_instr <= NOP_INSTR;
            id_pc    <= RESET_PC;
            id_valid <= 1'b0;
        end else if (redirect_valid) begin
            // Flush regardless of stall; any completion this cycle is dropped.
            id_instr <= NOP_INSTR;
            id_pc    <= redirect_pc;
            id_valid <= 1'b0;
        end else if (if_id_stall) begin
            id_instr <= id_instr;
            id_pc    <= id_pc;
            id_valid <= id_valid;
        end else if (skid_full) begin
            id_instr <= skid_instr;
            id_pc    <= skid_pc;
            id_valid <= 1'b1;
        end else if (fire) begin
            id_instr <= bus.imem_rdata;
            id_pc    <= pc_q;
            id_valid <= 1'b1;
        end else begin
            // Bubble keeps the last PC so hazard control sees a stable id_pc.
            id_instr <= NOP_INSTR;
            id_pc    <= id_pc;
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed stimulus, a transaction-level
// reference model updated per clock, per-cycle comparison on the falling
// edge, plus literal expectations at key points of each scenario.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic  clk;
    logic  rst;
    logic  if_id_stall;
    logic  redirect_valid;
    word_t redirect_pc;
    word_t id_instr, id_pc;
    logic  id_valid;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_id_stall    (if_id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_valid       (id_valid)
    );

    // Instruction memory: combinational read of the requested word.
    word_t mem [0:65535];
    assign bus.imem_rdata = mem[bus.imem_addr];

    int tests_run = 0;
    int tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        word_t instr;
        word_t pc;
    } entry_t;

    logic   m_known = 1'b0;
    word_t  m_pc;
    entry_t m_id;
    logic   m_id_valid;
    entry_t m_skid[$];

    task automatic model_step();
        if (rst) begin
            m_known    = 1'b1;
            m_pc       = 16'h0000;
            m_skid.delete();
            m_id       = '{16'h0000, 16'h0000};
            m_id_valid = 1'b0;
        end else if (!m_known) begin
            // Nothing defined before the first reset.
        end else if (redirect_valid) begin
            m_pc       = redirect_pc;
            m_skid.delete();
            m_id       = '{16'h0000, redirect_pc};
            m_id_valid = 1'b0;
        end else if (m_skid.size() != 0) begin
            // Request suppressed while a word waits in the skid buffer.
            if (!if_id_stall) begin
                m_id       = m_skid.pop_front();
                m_id_valid = 1'b1;
            end
        end else if (bus.imem_ready) begin
            if (if_id_stall) begin
                m_skid.push_back('{mem[m_pc], m_pc});
            end else begin
                m_id       = '{mem[m_pc], m_pc};
                m_id_valid = 1'b1;
            end
            m_pc = m_pc + 16'd1;
        end else if (!if_id_stall) begin
            m_id       = '{16'h0000, m_id.pc};
            m_id_valid = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_known) begin
            logic exp_req;
            exp_req = !rst && (m_skid.size() == 0);
            check("imem_req", {15'd0, bus.imem_req}, {15'd0, exp_req});
            if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
            check("id_instr", id_instr, m_id.instr);
            check("id_pc", id_pc, m_id.pc);
            check("id_valid", {15'd0, id_valid}, {15'd0, m_id_valid});
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic r, input logic st, input logic rdy,
                         input logic rv, input word_t rpc);
        rst            = r;
        if_id_stall    = st;
        bus.imem_ready = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input string name, input logic [15:0] act, input logic [15:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503 + 4369);
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        mem[7] = 16'hD0A3;

        // Reset
        apply(1, 0, 0, 0, 16'h0000);
        apply(1, 0, 0, 0, 16'h0000);
        pin("rst_id_valid", {15'd0, id_valid}, 16'h0000);
        pin("rst_id_instr", id_instr, 16'h0000);
        pin("rst_id_pc", id_pc, 16'h0000);
        pin("rst_req", {15'd0, bus.imem_req}, 16'h0000);

        // Back-to-back fetch with ready held high
        apply(0, 0, 1, 0, 16'h0000);
        pin("first_instr", id_instr, 16'h1234);
        pin("first_pc", id_pc, 16'h0000);
        pin("first_valid", {15'd0, id_valid}, 16'h0001);
        apply(0, 0, 1, 0, 16'h0000);
        pin("second_instr", id_instr, 16'h5678);
        pin("second_pc", id_pc, 16'h0001);
        apply(0, 0, 1, 0, 16'h0000);
        apply(0, 0, 1, 0, 16'h0000);
        pin("addr_at_4", bus.imem_addr, 16'h0004);

        // Memory not ready for 3 cycles at PC 4
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 16'h0000);
            pin("wait_addr", bus.imem_addr, 16'h0004);
            pin("wait_valid", {15'd0, id_valid}, 16'h0000);
            pin("wait_instr", id_instr, 16'h0000);
        end
        for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 16'h0000);
        pin("addr_at_7", bus.imem_addr, 16'h0007);

        // Stall during completion of PC 7 for two cycles
        apply(0, 1, 1, 0, 16'h0000);
        pin("hold_req0", {15'd0, bus.imem_req}, 16'h0000);
        pin("hold_id_pc0", id_pc, 16'h0006);
        apply(0, 1, 1, 0, 16'h0000);
        pin("hold_req1", {15'd0, bus.imem_req}, 16'h0000);
        pin("hold_id_pc1", id_pc, 16'h0006);
        apply(0, 0, 1, 0, 16'h0000);
        pin("drain_instr", id_instr, 16'hD0A3);
        pin("drain_pc", id_pc, 16'h0007);
        pin("drain_valid", {15'd0, id_valid}, 16'h0001);
        pin("drain_next_addr", bus.imem_addr, 16'h0008);
        pin("drain_next_req", {15'd0, bus.imem_req}, 16'h0001);
        apply(0, 0, 1, 0, 16'h0000);
        pin("after_drain_pc", id_pc, 16'h0008);

        // Redirect while holding a skid entry under stall
        apply(0, 1, 1, 0, 16'h0000);
        apply(0, 1, 0, 1, 16'h0040);
        pin("redir_valid", {15'd0, id_valid}, 16'h0000);
        pin("redir_id_pc", id_pc, 16'h0040);
        pin("redir_addr", bus.imem_addr, 16'h0040);
        pin("redir_req", {15'd0, bus.imem_req}, 16'h0001);
        apply(0, 0, 1, 0, 16'h0000);
        pin("redir_fetch_pc", id_pc, 16'h0040);
        pin("redir_fetch_valid", {15'd0, id_valid}, 16'h0001);

        // Redirect to the current PC still flushes and refetches
        apply(0, 0, 1, 1, 16'h0041);
        pin("self_redir_valid", {15'd0, id_valid}, 16'h0000);
        pin("self_redir_addr", bus.imem_addr, 16'h0041);
        apply(0, 0, 1, 0, 16'h0000);
        pin("self_refetch_pc", id_pc, 16'h0041);
        pin("self_next_addr", bus.imem_addr, 16'h0042);

        // PC wrap
        apply(0, 0, 0, 1, 16'hFFFF);
        pin("wrap_addr_ffff", bus.imem_addr, 16'hFFFF);
        apply(0, 0, 1, 0, 16'h0000);
        pin("wrap_id_pc", id_pc, 16'hFFFF);
        pin("wrap_addr_0", bus.imem_addr, 16'h0000);

        // Reset mid-stall with skid full
        apply(0, 1, 1, 0, 16'h0000);
        pin("pre_rst_req", {15'd0, bus.imem_req}, 16'h0000);
        apply(1, 1, 1, 1, 16'h0123);
        pin("mid_rst_valid", {15'd0, id_valid}, 16'h0000);
        pin("mid_rst_instr", id_instr, 16'h0000);
        pin("mid_rst_pc", id_pc, 16'h0000);
        pin("mid_rst_req", {15'd0, bus.imem_req}, 16'h0000);
        apply(0, 0, 0, 0, 16'h0000);
        pin("post_rst_req", {15'd0, bus.imem_req}, 16'h0001);
        pin("post_rst_addr", bus.imem_addr, 16'h0000);
        apply(0, 0, 1, 0, 16'h0000);
        pin("post_rst_instr", id_instr, 16'h1234);

        // Mixed stall / ready / redirect pattern, checked by the model
        for (int i = 0; i < 48; i++) begin
            apply(0, (i % 5 == 3) || (i % 7 == 0), (i % 3 != 1),
                  (i == 20) || (i == 33), 16'(i * 273));
        end
        apply(0, 0, 0, 0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, the PC loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 16'h0000, the bubble encoding driven into IF/ID.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_id_stall  input  1  from hazard control; hold IF/ID register contents.
REQ-006 redirect_valid  input  1  taken branch/jump resolved downstream.
REQ-007 redirect_pc  input  16  target word address for redirect.
REQ-008 imem_req  output  1  instruction memory request valid.
REQ-009 imem_addr  output  16  word address of request (equals PC).
REQ-010 imem_ready  input  1  memory accepts request and returns imem_rdata in the same cycle.
REQ-011 imem_rdata  input  16  fetched instruction; valid only when imem_req && imem_ready.
REQ-012 id_instr  output  16  IF/ID register instruction, consumed by decode and hazard control.
REQ-013 id_pc  output  16  PC of id_instr.
REQ-014 id_valid  output  1  id_instr is a real instruction (0 = bubble).

Function
REQ-015 FSM states SHALL be FETCH (imem_req=1) and HOLD (imem_req=0, skid buffer full).
REQ-016 Handshake completes in a cycle when imem_req && imem_ready; at most one outstanding request; imem_addr and imem_req SHALL stay stable until completion.
REQ-017 On completion with if_id_stall=0: IF/ID SHALL load {imem_rdata, PC, valid=1} at the next edge, PC <= PC+1 (16-bit wrap, 16'hFFFF -> 16'h0000), state stays FETCH.
REQ-018 On completion with if_id_stall=1: skid buffer SHALL capture {imem_rdata, PC}, PC <= PC+1, IF/ID unchanged, state -> HOLD.
REQ-019 In FETCH with no completion and if_id_stall=0: IF/ID SHALL load {NOP_INSTR, id_pc unchanged, valid=0}.
REQ-020 In FETCH or HOLD with if_id_stall=1: IF/ID SHALL hold all fields.
REQ-021 In HOLD with if_id_stall=0: IF/ID SHALL load skid contents with valid=1, skid empties, state -> FETCH; the next request issues in the following cycle (one-cycle issue gap).
REQ-022 redirect_valid SHALL have priority over all other events: PC <= redirect_pc, skid discarded, IF/ID <= {NOP_INSTR, redirect_pc, valid=0} regardless of if_id_stall, state -> FETCH; any completion in that cycle is discarded.
REQ-023 Redirect with redirect_pc equal to current PC SHALL still flush and refetch.
REQ-024 Fetch-to-id_instr latency SHALL be exactly one cycle when not stalled.
REQ-025 imem_req SHALL depend only on state (no combinational path from inputs).

Reset
REQ-026 On rst=1 at a rising edge: PC=RESET_PC, state=FETCH, skid empty, id_instr=NOP_INSTR, id_pc=RESET_PC, id_valid=0.
REQ-027 rst SHALL override redirect_valid and any in-progress handshake; imem_req SHALL be 0 during any cycle with rst=1.
REQ-028 First request SHALL issue in the first cycle after rst deasserts, at RESET_PC.

Structure
REQ-029 NOP_INSTR, RESET_PC default and FSM state encoding SHALL live in the shared core package, also used by decode and hazard control.
REQ-030 The skid buffer SHALL be a sub-module fetch_skid_buf (1-entry, data+pc+full, load/drain/flush).

Verification
REQ-031 Reset, imem_ready=1 constantly, words 0x1234,0x5678 at 0,1 -> id_instr 0x1234/id_pc 0 one cycle after first req, then 0x5678/1, id_valid=1.
REQ-032 imem_ready=0 for 3 cycles at PC 4 -> imem_addr held at 4, id_valid=0 and id_instr=0x0000 for 3 cycles.
REQ-033 if_id_stall=1 during completion of PC 7 (0xD0A3) for 2 cycles -> IF/ID holds, imem_req=0 in HOLD, 0xD0A3/7 appears the cycle stall drops, next req at 8.
REQ-034 redirect_valid=1, redirect_pc=0x0040 while in HOLD with stall=1 -> skid dropped, id_valid=0, next imem_addr=0x0040.
REQ-035 PC at 0xFFFF completes -> next imem_addr=0x0000.
REQ-036 rst asserted mid-stall with skid full -> all outputs at reset values next cycle, req at RESET_PC after release.
